// File: rtl/systolic_edge_feeder_if.sv
// systolic_edge_feeder_if: valid/ready vector stream into the edge feeder.
interface systolic_edge_feeder_if #(parameter int N = 4) ();
   logic             in_valid;
   logic             in_ready;
   logic [32*N-1:0]  in_data;
   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder: skews K-slice vectors so lane i lags by i cycles into one array edge.
// Define FEED_CANON_ZERO_EN to replace -0.0 lane values with +0.0 before the skew chain.
module systolic_edge_feeder #(
   parameter int N  = 4,
   parameter int KW = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [KW-1:0]        k_len_i,
   systolic_edge_feeder_if.slave in_if,
   output logic [32*N-1:0]      out_lane_o,
   output logic [N-1:0]         out_act_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 underrun_o
);
   localparam int FW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;
   state_t         state_q, state_d;
   logic           pend_q, pend_d;
   logic [KW-1:0]  klen_q, klen_d, cnt_q, cnt_d;
   logic [FW-1:0]  fl_q, fl_d;
   logic           und_q, und_d;
   logic           acc;
   function automatic logic [31:0] canon(input logic [31:0] x);
`ifdef FEED_CANON_ZERO_EN
      return (x == 32'h8000_0000) ? 32'h0 : x;
`else
      return x;
`endif
   endfunction
   // START is registered once in IDLE; the pass begins on the following edge
   always_comb begin
      state_d = state_q;
      pend_d  = 1'b0;
      klen_d  = klen_q;
      cnt_d   = cnt_q;
      fl_d    = fl_q;
      und_d   = und_q;
      acc     = (state_q == S_STREAM) && in_if.in_valid;
      case (state_q)
         S_IDLE: begin
            pend_d = start_i && !pend_q;
            if (start_i && !pend_q) begin
               klen_d = k_len_i;
               cnt_d  = '0;
               und_d  = 1'b0;
            end
            if (pend_q) state_d = (klen_q != '0) ? S_STREAM : S_DONE;
         end
         S_STREAM: begin
            if (acc) begin
               cnt_d = cnt_q + 1'b1;
               fl_d  = '0;
               if (cnt_d == klen_q) state_d = (N == 1) ? S_DONE : S_FLUSH;
            end else begin
               und_d = 1'b1;
            end
         end
         S_FLUSH: begin
            fl_d = fl_q + 1'b1;
            if (fl_q == FW'(N - 2)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pend_q  <= 1'b0;
         klen_q  <= '0;
         cnt_q   <= '0;
         fl_q    <= '0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         klen_q  <= klen_d;
         cnt_q   <= cnt_d;
         fl_q    <= fl_d;
         und_q   <= und_d;
      end
   end
   assign in_if.in_ready = (state_q == S_STREAM);
   assign busy_o         = (state_q != S_IDLE);
   assign done_o         = (state_q == S_DONE);
   assign underrun_o     = und_q;
   // lane i: i+1 stages of data plus an activity tag; zeros enter whenever nothing is accepted
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [31:0] d_q [i+1];
      logic        a_q [i+1];
      logic [31:0] v;
      assign v = acc ? canon(in_if.in_data[32*i +: 32]) : 32'h0;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int j = 0; j <= i; j++) begin
               d_q[j] <= '0;
               a_q[j] <= 1'b0;
            end
         end else begin
            d_q[0] <= v;
            a_q[0] <= acc;
            for (int j = 1; j <= i; j++) begin
               d_q[j] <= d_q[j-1];
               a_q[j] <= a_q[j-1];
            end
         end
      end
      assign out_lane_o[32*i +: 32] = d_q[i];
      assign out_act_o[i]           = a_q[i];
   end
endmodule

// File: tb/tb_systolic_edge_feeder.sv
// tb_systolic_edge_feeder: timeline model of skewed outputs checked every cycle, plus literal spot checks.
module tb_systolic_edge_feeder;
   localparam int N    = 4;
   localparam int KW   = 16;
   localparam int NCYC = 512;
   logic            clk, rst_n, start, done, busy, und;
   logic [KW-1:0]   k_len;
   logic [32*N-1:0] out_lane;
   logic [N-1:0]    out_act;
   int              cyc = 0;
   int              checks = 0, failures = 0;
   bit              chk_en = 0;
   logic [31:0]     exp_data [NCYC][N];
   bit              exp_act  [NCYC][N];
   bit              exp_done [NCYC], exp_busy [NCYC], exp_rdy [NCYC];
   logic [32*N-1:0] obs_lane [NCYC];
   logic [N-1:0]    obs_act  [NCYC];
   logic            obs_done [NCYC];
   logic [32*N-1:0] vec [8];
   bit              vld [8];
   systolic_edge_feeder_if #(.N(N)) bus ();
   systolic_edge_feeder #(.N(N), .KW(KW)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .k_len_i(k_len), .in_if(bus.slave),
      .out_lane_o(out_lane), .out_act_o(out_act), .busy_o(busy), .done_o(done), .underrun_o(und));
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [31:0] mcanon(input logic [31:0] x);
`ifdef FEED_CANON_ZERO_EN
      return (x == 32'h8000_0000) ? 32'h0 : x;
`else
      return x;
`endif
   endfunction
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask
   task automatic clear_exp();
      for (int t = 0; t < NCYC; t++) begin
         for (int i = 0; i < N; i++) begin
            exp_data[t][i] = '0;
            exp_act[t][i]  = 0;
         end
         exp_done[t] = 0;
         exp_busy[t] = 0;
         exp_rdy[t]  = 0;
         obs_done[t] = 0;
         obs_lane[t] = '0;
         obs_act[t]  = '0;
      end
   endtask
   always @(negedge clk) begin : cmp
      logic [127:0] el;
      logic [N-1:0] ea;
      if (chk_en && rst_n && cyc < NCYC) begin
         for (int i = 0; i < N; i++) begin
            el[32*i +: 32] = exp_data[cyc][i];
            ea[i]          = exp_act[cyc][i];
         end
         obs_lane[cyc] = out_lane;
         obs_act[cyc]  = out_act;
         obs_done[cyc] = done;
         chk($sformatf("lane@%0d", cyc), out_lane, el);
         chk($sformatf("act@%0d", cyc), 128'(out_act), 128'(ea));
         chk($sformatf("done@%0d", cyc), 128'(done), 128'(exp_done[cyc]));
         chk($sformatf("busy@%0d", cyc), 128'(busy), 128'(exp_busy[cyc]));
         chk($sformatf("ready@%0d", cyc), 128'(bus.in_ready), 128'(exp_rdy[cyc]));
      end
   end
   // Whole schedule derived from the pattern: slot j is offered after edge s+1+j, accepted at s+2+j
   task automatic run_pass(input int k, input int nslots, input bit flush_start,
                           output int s, output int first, output int last);
      int c0, cur, endc;
      c0 = cyc + 1;
      s = c0 + 1;
      first = -1;
      last = s + 1;
      for (int j = 0; j < nslots; j++) begin
         if (vld[j]) begin
            if (first < 0) first = s + 2 + j;
            last = s + 2 + j;
            for (int i = 0; i < N; i++) begin
               exp_data[last+i][i] = mcanon(vec[j][32*i +: 32]);
               exp_act[last+i][i]  = 1;
            end
         end
      end
      if (k == 0) begin
         exp_done[s+1] = 1;
         exp_busy[s+1] = 1;
         endc = s + 3;
      end else begin
         exp_done[last+N-1] = 1;
         for (int t = s + 1; t <= last + N - 1; t++) exp_busy[t] = 1;
         for (int t = s + 1; t < last; t++) exp_rdy[t] = 1;
         endc = last + N + 1;
      end
      @(negedge clk);
      start = 1;
      k_len = KW'(k);
      @(negedge clk);
      start = 0;
      @(negedge clk);
      if (k != 0) begin
         for (int j = 0; j < nslots; j++) begin
            bus.in_valid = vld[j];
            bus.in_data  = vld[j] ? vec[j] : {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
         end
      end
      bus.in_valid = 0;
      cur = cyc;
      while (cur < endc) begin
         start = flush_start && (cur == last);
         k_len = flush_start ? KW'(9) : k_len;
         @(negedge clk);
         cur = cyc;
      end
      start = 0;
   endtask
   initial begin
      int s, a0, al;
      rst_n = 0;
      start = 0;
      k_len = 0;
      bus.in_valid = 0;
      bus.in_data = '0;
      clear_exp();
      #1;
      chk("rst_lane", out_lane, 128'h0);
      chk("rst_act", 128'(out_act), 128'h0);
      chk("rst_busy", 128'(busy), 128'h0);
      chk("rst_done", 128'(done), 128'h0);
      chk("rst_und", 128'(und), 128'h0);
      chk("rst_ready", 128'(bus.in_ready), 128'h0);
      @(negedge clk);
      rst_n = 1;
      chk_en = 1;
      repeat (2) @(negedge clk);
      // full pass K=3
      vec[0] = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
      vec[1] = {32'h1111_1113, 32'h1111_1112, 32'h1111_1111, 32'h1111_1110};
      vec[2] = {32'hC100_0000, 32'h2222_2222, 32'h2222_2221, 32'h2222_2220};
      vld[0] = 1; vld[1] = 1; vld[2] = 1;
      run_pass(3, 3, 0, s, a0, al);
      chk("full_v0_lane0", 128'(obs_lane[a0][31:0]), 128'h3F80_0000);
      chk("full_v0_lane3", 128'(obs_lane[a0+3][127:96]), 128'h4080_0000);
      chk("full_done", 128'(obs_done[a0+5]), 128'h1);
      chk("full_done_lane3", 128'(obs_lane[a0+5][127:96]), 128'hC100_0000);
      chk("full_und", 128'(und), 128'h0);
      // underrun: V0, gap, V1
      vec[0] = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
      vec[2] = {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
      vld[0] = 1; vld[1] = 0; vld[2] = 1;
      run_pass(2, 3, 0, s, a0, al);
      chk("und_bubble_act", 128'(obs_act[a0+1]), 128'h2);
      chk("und_bubble_lane3_act", 128'(obs_act[a0+4][3]), 128'h0);
      chk("und_done_early", 128'(obs_done[a0+4]), 128'h0);
      chk("und_done", 128'(obs_done[a0+5]), 128'h1);
      chk("und_flag", 128'(und), 128'h1);
      repeat (3) @(negedge clk);
      chk("und_sticky", 128'(und), 128'h1);
      // empty pass
      run_pass(0, 0, 0, s, a0, al);
      chk("empty_done_first", 128'(obs_done[s]), 128'h0);
      chk("empty_done", 128'(obs_done[s+1]), 128'h1);
      chk("empty_und_clr", 128'(und), 128'h0);
      // -0.0 on lane 2
      vec[0] = {32'h0000_0003, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001};
      vld[0] = 1;
      run_pass(1, 1, 0, s, a0, al);
`ifdef FEED_CANON_ZERO_EN
      chk("canon_lane2", 128'(obs_lane[a0+2][95:64]), 128'h0);
`else
      chk("canon_lane2", 128'(obs_lane[a0+2][95:64]), 128'h8000_0000);
`endif
      chk("canon_act2", 128'(obs_act[a0+2][2]), 128'h1);
      chk("canon_lane0", 128'(obs_lane[a0][31:0]), 128'h8000_0001);
      // START during FLUSH is ignored
      vec[0] = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
      vec[1] = {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000};
      vld[0] = 1; vld[1] = 1;
      run_pass(2, 2, 1, s, a0, al);
      repeat (4) @(negedge clk);
      chk("flush_start_idle", 128'(busy), 128'h0);
      // asynchronous reset mid-STREAM
      chk_en = 0;
      start = 1;
      k_len = 4;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1;
      bus.in_data = vec[0];
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_act", 128'(out_act), 128'h3);
      chk("pre_rst_busy", 128'(busy), 128'h1);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_lane", out_lane, 128'h0);
      chk("mid_rst_act", 128'(out_act), 128'h0);
      chk("mid_rst_busy", 128'(busy), 128'h0);
      chk("mid_rst_ready", 128'(bus.in_ready), 128'h0);
      bus.in_valid = 0;
      clear_exp();
      @(negedge clk);
      rst_n = 1;
      chk_en = 1;
      repeat (8) @(negedge clk);
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/systolic_edge_feeder.md
# systolic_edge_feeder

Skewing input feeder that drives one edge (left or top) of the N×N FP32 systolic multiply array. It accepts one K-slice vector per cycle through a valid/ready handshake and emits lane i delayed by i cycles, so operand wavefronts reach the processing elements diagonally aligned. Bubbles are driven as FP32 zero, which the PEs treat as no-ops. One instance feeds rows of A on the left edge and a second instance feeds columns of B on the top edge. Both instances are started by the same START pulse.

## Interface
- N, default 4: number of lanes (array rows or columns), N ≥ 1.
- KW, default 16: width of the K-length field.
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle pulse; begins a new matrix pass. Sampled only in IDLE.
- K_LEN  in  KW  number of vectors in the pass; latched on an accepted START.
- IN_VALID  in  1  IN_DATA holds a valid vector.
- IN_READY  out  1  feeder accepts a vector this cycle.
- IN_DATA  in  32*N  vector; lane i is IN_DATA[32*i +: 32].
- OUT_LANE  out  32*N  skewed edge operands; lane i drives array row or column i.
- OUT_ACT  out  N  lane i carries real data, not a bubble.
- BUSY  out  1  high in STREAM, FLUSH and DONE.
- DONE  out  1  one-cycle pass-complete pulse.
- UNDERRUN  out  1  sticky; set when a bubble was inserted mid-stream.

## Operation
- States: IDLE, STREAM, FLUSH, DONE.
- **IDLE**
  - IN_READY = 0.
  - START=1 latches K_LEN and clears UNDERRUN and the accept counter.
  - If K_LEN ≠ 0, next state is STREAM. If K_LEN = 0, next state is DONE.
  - START in any other state is ignored.
- **STREAM**
  - IN_READY = 1 every cycle, with no backpressure: the array cannot stall.
  - A vector is accepted when IN_VALID=1. Each accepted vector increments the KW-bit accept counter.
  - If IN_VALID=0, a zero vector (all lanes 32'h0000_0000, OUT_ACT bits 0) enters lane 0 and UNDERRUN is set. Bubbles do not count toward K_LEN.
  - Acceptance of vector number K_LEN moves the state to FLUSH.
- **FLUSH**
  - IN_READY = 0. Zero vectors are injected for N−1 cycles so the skew registers drain.
  - Then the state moves to DONE. With N=1, FLUSH lasts 0 cycles.
- **DONE**
  - DONE = 1 for exactly one cycle, then the state returns to IDLE.
- **Skew datapath**
  - Lane i is a chain of i+1 registers, so lane 0 has one register stage.
  - Every stage shifts every cycle in every state, including IDLE, where zero vectors are injected.
  - OUT_ACT[i] travels through the same chain as a tag bit.
- Lane values are passed bit-exact. There is no arithmetic on operands, except the optional zero canonicalisation (see Configuration).

## Timing
- Reset (RST_N=0, asynchronous):
  - State = IDLE; all skew registers and OUT_LANE = 0; OUT_ACT = 0.
  - IN_READY = 0, BUSY = 0, DONE = 0, UNDERRUN = 0, accept counter = 0.
- Reset asserted mid-pass aborts the pass immediately. No DONE pulse is produced. After release the block is in IDLE.
- START sampled at edge s: IN_READY = 1 from edge s+1.
- Vector accepted at edge a: lane i of that vector appears on OUT_LANE, with OUT_ACT[i]=1, after edge a+i. This is valid for one cycle.
- Last vector accepted at edge a: DONE is high in the cycle after edge a+N−1, coinciding with that vector's lane N−1 datum on OUT_LANE.
- K_LEN=0: DONE is high in the cycle after edge s+1.
- Back-to-back passes: START may be asserted in the cycle after DONE, while the block is in IDLE. It is ignored if asserted during DONE.

## Configuration
- `FEED_CANON_ZERO_EN` defined: any lane value 32'h8000_0000 (−0.0) is replaced by 32'h0000_0000 before entering the skew chain. OUT_ACT is unaffected. This keeps the PE zero-skip paths engaged.
- Undefined: −0.0 is passed verbatim.

## Test plan
- Reset: drive RST_N=0 mid-STREAM with N=4. Required: OUT_LANE=0, OUT_ACT=0, BUSY=0, IN_READY=0 with no clock edge. After release, no DONE pulse appears.
- Full pass: N=4, K_LEN=3, vectors V0..V2 valid on consecutive cycles.
  - V0 lane 0 appears 1 edge after acceptance; V0 lane 3 appears 4 edges after acceptance.
  - DONE is high exactly when V2 lane 3 is on OUT_LANE.
  - UNDERRUN = 0.
- Underrun: K_LEN=2 with IN_VALID low for one cycle between V0 and V1.
  - A zero bubble (OUT_ACT=0) appears in every lane between V0 and V1.
  - DONE is delayed by one cycle.
  - UNDERRUN = 1 until the next START.
- Empty pass: K_LEN=0, START=1.
  - DONE pulses in the second cycle after START.
  - OUT_ACT stays 0 and IN_READY stays 0.
- Canonicalisation: V0 lane 2 = 32'h8000_0000.
  - With `FEED_CANON_ZERO_EN` defined, lane 2 outputs 32'h0000_0000 with OUT_ACT[2]=1.
  - Without the macro, lane 2 outputs 32'h8000_0000.
- START while busy: pulse START during FLUSH. Required: no effect, a single DONE, and K_LEN is not relatched.
